// File: rtl/pintar_capas.sv
// Two-stage layered pixel painter: player, obstacles, verge, background.
// Also reports whether the player touched any obstacle during each frame.
module pintar_capas #(
  parameter int N_OBST    = 3,
  parameter int ANCHO     = 65,
  parameter int ALTO      = 70,
  parameter int Y_JUGADOR = 390,
  parameter int BORDE_IZQ = 215,
  parameter int BORDE_DER = 405,
  parameter int H_ACTIVO  = 640,
  parameter int V_ACTIVO  = 480
) (
  input  logic                  clk,
  input  logic                  iReset_n,
  input  logic [10:0]           iPixelX,
  input  logic [9:0]            iPixelY,
  input  logic                  iPixelValido,
  input  logic                  iPintarCarros,
  input  logic                  iPintarJugador,
  input  logic [10*N_OBST-1:0]  iPosX,
  input  logic [9*N_OBST-1:0]   iPosY,
  input  logic [9:0]            iPosJugador,
  output logic [2:0]            oColorRGB,
  output logic                  oPixelValido,
  output logic                  oColision,
  output logic                  oColisionPulso
);

  localparam logic [11:0] AN   = 12'(ANCHO);
  localparam logic [11:0] AL   = 12'(ALTO);
  localparam logic [11:0] YJ   = 12'(Y_JUGADOR);
  localparam logic [11:0] YJF  = 12'(Y_JUGADOR + ALTO);
  localparam logic [11:0] BIZ  = 12'(BORDE_IZQ);
  localparam logic [11:0] BDE  = 12'(BORDE_DER);
  localparam logic [11:0] VA   = 12'(V_ACTIVO);
  localparam logic [11:0] XFIN = 12'(H_ACTIVO - 1);
  localparam logic [11:0] YFIN = 12'(V_ACTIVO - 1);

  localparam logic [2:0] C_JUG   = 3'd7;
  localparam logic [2:0] C_OBS   = 3'd1;
  localparam logic [2:0] C_BORDE = 3'd3;
  localparam logic [2:0] C_FONDO = 3'd0;

  typedef enum logic [1:0] {
    ESPERA,
    ACUM,
    REPORTE
  } estado_t;

  logic [11:0] x_w;
  logic [11:0] y_w;
  logic [11:0] pj_x;
  logic [11:0] pj_xf;

  assign x_w   = {1'b0, iPixelX};
  assign y_w   = {2'b0, iPixelY};
  assign pj_x  = {2'b0, iPosJugador};
  assign pj_xf = pj_x + AN;

  logic [N_OBST-1:0] hit_obs;
  logic              hit_jug;
  logic              hit_borde;

  // Obstacles running off the bottom reappear at the top rows.
  for (genvar k = 0; k < N_OBST; k++) begin : g_obs
    logic [11:0] ox;
    logic [11:0] oy;
    logic [11:0] ox_f;
    logic [11:0] oy_f;
    logic        en_x;
    logic        en_y;
    logic        en_wrap;

    assign ox      = {2'b0, iPosX[10*k +: 10]};
    assign oy      = {3'b0, iPosY[9*k +: 9]};
    assign ox_f    = ox + AN;
    assign oy_f    = oy + AL;
    assign en_x    = (x_w >= ox) && (x_w < ox_f);
    assign en_y    = (y_w >= oy) && (y_w < oy_f);
    assign en_wrap = (oy_f > VA) && (y_w < (oy_f - VA));
    assign hit_obs[k] = en_x && (en_y || en_wrap);
  end

  assign hit_jug = (x_w >= pj_x) && (x_w < pj_xf) &&
                   (y_w >= YJ) && (y_w < YJF);

  assign hit_borde = (x_w < BIZ) || (x_w > BDE);

  logic              en_carros;
  logic              en_jug;

  assign en_carros = iPixelValido && iPintarCarros;
  assign en_jug    = iPixelValido && iPintarJugador;

  // Stage 1: gated per-layer flags plus frame markers.
  logic [N_OBST-1:0] obs_d, obs_q;
  logic              jug_d, jug_q;
  logic              borde_d, borde_q;
  logic              val1_d, val1_q;
  logic              ori_d, ori_q;
  logic              fin_d, fin_q;

  assign obs_d   = hit_obs & {N_OBST{en_carros}};
  assign jug_d   = hit_jug && en_jug;
  assign borde_d = hit_borde && en_carros;
  assign val1_d  = iPixelValido;
  assign ori_d   = iPixelValido && (x_w == 12'd0) && (y_w == 12'd0);
  assign fin_d   = iPixelValido && (x_w == XFIN) && (y_w == YFIN);

  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      obs_q   <= '0;
      jug_q   <= 1'b0;
      borde_q <= 1'b0;
      val1_q  <= 1'b0;
      ori_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      obs_q   <= obs_d;
      jug_q   <= jug_d;
      borde_q <= borde_d;
      val1_q  <= val1_d;
      ori_q   <= ori_d;
      fin_q   <= fin_d;
    end
  end

  // Stage 2: priority resolve; every obstacle channel shares one colour.
  logic [2:0] color_d, color_q;
  logic       val2_q;

  always_comb begin
    color_d = C_FONDO;
    if (jug_q) begin
      color_d = C_JUG;
    end else if (|obs_q) begin
      color_d = C_OBS;
    end else if (borde_q) begin
      color_d = C_BORDE;
    end
  end

  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      color_q <= C_FONDO;
      val2_q  <= 1'b0;
    end else begin
      color_q <= color_d;
      val2_q  <= val1_q;
    end
  end

  assign oColorRGB    = color_q;
  assign oPixelValido = val2_q;

  // Frame collision tracker, fed from stage 1.
  estado_t est_d, est_q;
  logic    acc_d, acc_q;
  logic    col_d, col_q;
  logic    pul_d, pul_q;
  logic    choque;

  assign choque = jug_q && (|obs_q);

  always_comb begin
    est_d = est_q;
    acc_d = acc_q;
    col_d = col_q;
    pul_d = 1'b0;
    unique case (est_q)
      ESPERA: begin
        if (ori_q) begin
          est_d = ACUM;
          acc_d = 1'b0;
        end
      end
      ACUM: begin
        if (ori_q) begin
          acc_d = 1'b0;
        end else begin
          acc_d = acc_q || choque;
          if (fin_q) begin
            est_d = REPORTE;
          end
        end
      end
      REPORTE: begin
        col_d = acc_q;
        pul_d = 1'b1;
        est_d = ESPERA;
        if (ori_q) begin
          est_d = ACUM;
          acc_d = 1'b0;
        end
      end
      default: begin
        est_d = ESPERA;
        acc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      est_q <= ESPERA;
      acc_q <= 1'b0;
      col_q <= 1'b0;
      pul_q <= 1'b0;
    end else begin
      est_q <= est_d;
      acc_q <= acc_d;
      col_q <= col_d;
      pul_q <= pul_d;
    end
  end

  assign oColision      = col_q;
  assign oColisionPulso = pul_q;

endmodule

// File: tb/tb_pintar_capas.sv
// Scoreboard bench for pintar_capas: three parameterisations share one pixel stream.
// Instance a: defaults, b: N_OBST=8/ANCHO=32, c: N_OBST=1.
module tb_pintar_capas;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] px = '0;
  logic [9:0]  py = '0;
  logic        pv = 1'b0;
  logic        pc = 1'b0;
  logic        pj = 1'b0;
  logic [9:0]  pjug = '0;

  int ox [3][8];
  int oy [3][8];
  int nobs [3] = '{3, 8, 1};
  int anc  [3] = '{65, 32, 65};

  logic [29:0] bxa;
  logic [26:0] bya;
  logic [79:0] bxb;
  logic [71:0] byb;
  logic [9:0]  bxc;
  logic [8:0]  byc;

  always_comb begin
    bxa = '0;
    bya = '0;
    bxb = '0;
    byb = '0;
    for (int k = 0; k < 3; k++) begin
      bxa[10*k +: 10] = 10'(ox[0][k]);
      bya[9*k +: 9]   = 9'(oy[0][k]);
    end
    for (int k = 0; k < 8; k++) begin
      bxb[10*k +: 10] = 10'(ox[1][k]);
      byb[9*k +: 9]   = 9'(oy[1][k]);
    end
    bxc = 10'(ox[2][0]);
    byc = 9'(oy[2][0]);
  end

  logic [2:0] col_a, col_b, col_c;
  logic       vo_a, vo_b, vo_c;
  logic       co_a, co_b, co_c;
  logic       pu_a, pu_b, pu_c;

  pintar_capas u_a (
    .clk(clk), .iReset_n(rst_n),
    .iPixelX(px), .iPixelY(py), .iPixelValido(pv),
    .iPintarCarros(pc), .iPintarJugador(pj),
    .iPosX(bxa), .iPosY(bya), .iPosJugador(pjug),
    .oColorRGB(col_a), .oPixelValido(vo_a),
    .oColision(co_a), .oColisionPulso(pu_a)
  );

  pintar_capas #(.N_OBST(8), .ANCHO(32)) u_b (
    .clk(clk), .iReset_n(rst_n),
    .iPixelX(px), .iPixelY(py), .iPixelValido(pv),
    .iPintarCarros(pc), .iPintarJugador(pj),
    .iPosX(bxb), .iPosY(byb), .iPosJugador(pjug),
    .oColorRGB(col_b), .oPixelValido(vo_b),
    .oColision(co_b), .oColisionPulso(pu_b)
  );

  pintar_capas #(.N_OBST(1)) u_c (
    .clk(clk), .iReset_n(rst_n),
    .iPixelX(px), .iPixelY(py), .iPixelValido(pv),
    .iPintarCarros(pc), .iPintarJugador(pj),
    .iPosX(bxc), .iPosY(byc), .iPosJugador(pjug),
    .oColorRGB(col_c), .oPixelValido(vo_c),
    .oColision(co_c), .oColisionPulso(pu_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    int    ec [3];
    bit    ev;
    string nm;
  } exp_t;

  exp_t sb [$];
  bit   fq [$];
  int   ntests = 0;
  int   nfail = 0;
  bit   infr = 1'b0;
  bit   acc = 1'b0;

  task automatic chk(input string nm, input int got, input int want);
    ntests++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic bit ohit(input int i, input int k, input int x, input int y);
    int top;
    top = oy[i][k] + 70;
    return (x >= ox[i][k]) && (x < ox[i][k] + anc[i]) &&
           (((y >= oy[i][k]) && (y < top)) || (y < top - 480));
  endfunction

  function automatic bit any_obs(input int i, input int x, input int y);
    for (int k = 0; k < nobs[i]; k++)
      if (ohit(i, k, x, y)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit phit(input int i, input int x, input int y);
    int p;
    p = int'(pjug);
    return (x >= p) && (x < p + anc[i]) && (y >= 390) && (y < 460);
  endfunction

  function automatic int model(input int i, input int x, input int y);
    if (!pv) return 0;
    if (pj && phit(i, x, y)) return 7;
    if (pc) begin
      if (any_obs(i, x, y)) return 1;
      if (x < 215 || x > 405) return 3;
    end
    return 0;
  endfunction

  task automatic drive(input int x, input int y, input bit v,
                       input int ea, input int eb, input string nm);
    exp_t e;
    bit   hit;
    px = 11'(x);
    py = 10'(y);
    pv = v;
    e.due = cyc + 2;
    e.ev  = v;
    e.nm  = nm;
    for (int i = 0; i < 3; i++) e.ec[i] = model(i, x, y);
    if (ea >= 0) e.ec[0] = ea;
    if (eb >= 0) e.ec[1] = eb;
    sb.push_back(e);
    hit = v && pj && pc && phit(0, x, y) && any_obs(0, x, y);
    if (v) begin
      if (x == 0 && y == 0) begin
        infr = 1'b1;
        acc  = 1'b0;
      end else if (infr) begin
        acc = acc | hit;
        if (x == 639 && y == 479) begin
          fq.push_back(acc);
          infr = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    pv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, -1, -1, "idle");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pv = 1'b0;
    #1;
    chk("rst_col_a", int'(col_a), 0);
    chk("rst_vo_a", int'(vo_a), 0);
    chk("rst_coll_a", int'(co_a), 0);
    chk("rst_pulse_a", int'(pu_a), 0);
    chk("rst_any_bc", int'({col_b, col_c, vo_b, vo_c, co_b, co_c, pu_b, pu_c}), 0);
    sb.delete();
    fq.delete();
    infr = 1'b0;
    acc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) begin
        ox[i][k] = 900;
        oy[i][k] = 0;
      end
  endtask

  task automatic rand_pix(input int n);
    int x, y;
    bit v;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, 639);
      y = ($urandom % 2 == 0) ? $urandom_range(370, 479) : $urandom_range(0, 479);
      v = ($urandom % 10) != 0;
      drive(x, y, v, -1, -1, "rand");
    end
  endtask

  task automatic frame_rand(input int n);
    bit low;
    low = ($urandom % 2) == 0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < nobs[i]; k++) begin
        ox[i][k] = $urandom_range(150, 520);
        oy[i][k] = low ? $urandom_range(300, 511) : $urandom_range(0, 511);
      end
    pjug = 10'($urandom_range(150, 480));
    pc = ($urandom % 6) != 0;
    pj = ($urandom % 6) != 0;
    drive(0, 0, 1'b1, -1, -1, "rf_org");
    rand_pix(n);
    drive(639, 479, 1'b1, -1, -1, "rf_fin");
    idle(4);
  endtask

  initial begin : monitor
    exp_t e;
    bit   b;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk({e.nm, "_stale"}, cyc, e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk({e.nm, "_col_a"}, int'(col_a), e.ec[0]);
        chk({e.nm, "_col_b"}, int'(col_b), e.ec[1]);
        chk({e.nm, "_col_c"}, int'(col_c), e.ec[2]);
        chk({e.nm, "_valid"}, int'({vo_a, vo_b, vo_c}), e.ev ? 7 : 0);
      end
      if (pu_a) begin
        if (fq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          b = fq.pop_front();
          chk("frame_collision", int'(co_a), int'(b));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    clear_obs();
    do_reset();

    pc = 1'b1;
    pj = 1'b0;
    ox[0][0] = 300; oy[0][0] = 100;
    ox[1][0] = 300; oy[1][0] = 100;
    drive(300, 100, 1'b1, 1, -1, "obs0_hit");
    drive(365, 100, 1'b1, 0, -1, "obs0_xedge");
    drive(100, 100, 1'b1, 3, -1, "verge");
    drive(331, 100, 1'b1, -1, 1, "anc32_in");
    drive(332, 100, 1'b1, -1, 0, "anc32_out");

    clear_obs();
    ox[0][1] = 250; oy[0][1] = 450;
    ox[2][0] = 250; oy[2][0] = 450;
    for (int y = 0; y < 40; y++) drive(260, y, 1'b1, 1, -1, "wrap_in");
    drive(260, 40, 1'b1, 0, -1, "wrap_out");
    drive(260, 470, 1'b1, 1, -1, "wrap_top");
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) ox[1][j] = 900;
      ox[1][k] = 250;
      oy[1][k] = 450;
      drive(260, 5, 1'b1, -1, 1, "wrapb_in");
      drive(281, 39, 1'b1, -1, 1, "wrapb_corner");
      drive(282, 39, 1'b1, -1, 0, "wrapb_xout");
    end

    clear_obs();
    ox[0][0] = 300; oy[0][0] = 180;
    ox[0][2] = 310; oy[0][2] = 190;
    drive(320, 200, 1'b1, 1, -1, "ovl");
    pc = 1'b0;
    drive(320, 200, 1'b1, 0, -1, "ovl_off");
    pc = 1'b1;
    ox[0][0] = 900;
    drive(320, 200, 1'b1, 1, -1, "ovl_ch2");
    ox[0][0] = 300;
    drive(320, 200, 1'b0, 0, -1, "ovl_inv");

    clear_obs();
    pjug = 10'd300;
    ox[0][0] = 300; oy[0][0] = 380;
    pc = 1'b1;
    pj = 1'b1;
    drive(0, 0, 1'b1, -1, -1, "f1_org");
    drive(310, 395, 1'b1, 7, -1, "f1_player");
    rand_pix(20);
    drive(639, 479, 1'b1, -1, -1, "f1_fin");
    idle(5);
    chk("f1_collision_hold", int'(co_a), 1);
    chk("f1_report_done", fq.size(), 0);

    ox[0][0] = 900;
    drive(0, 0, 1'b1, -1, -1, "f2_org");
    drive(310, 395, 1'b1, 7, -1, "f2_player");
    rand_pix(20);
    drive(639, 479, 1'b1, -1, -1, "f2_fin");
    idle(5);
    chk("f2_collision_clear", int'(co_a), 0);

    ox[0][0] = 300;
    drive(0, 0, 1'b1, -1, -1, "f3_org");
    drive(310, 395, 1'b1, 7, -1, "f3_player");
    do_reset();
    drive(310, 395, 1'b1, 7, -1, "f3_post_rst");
    drive(639, 479, 1'b1, -1, -1, "f3_fin");
    idle(5);
    chk("f3_no_report", int'(co_a), 0);
    drive(0, 0, 1'b1, -1, -1, "f4_org");
    drive(320, 400, 1'b1, 7, -1, "f4_player");
    drive(639, 479, 1'b1, -1, -1, "f4_fin");
    idle(5);
    chk("f4_collision", int'(co_a), 1);

    for (int f = 0; f < 25; f++) frame_rand(300);

    idle(6);
    chk("pending_reports", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
